xylo_bar_renderer: RTL and testbench

Parametrised pixel generator for the xylophone VGA display: draws NUM_BARS vertical bars and lights each one up when its strike input pulses. Brightness then decays once per video frame. Sits between the VGA timing generator, which supplies pixel_x and pixel_y, and the RGB output stage, replacing the fixed single-mode drawing logic. It runs entirely in the pixel clock domain.

---
 rtl/xylo_bar_renderer.sv | 140 ++++++++++++++
 tb/tb_xylo_bar_renderer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/xylo_bar_renderer.sv
// -----------------------------------------------------------------------------
// xylo_bar_renderer
//
// Pixel generator for the xylophone VGA display. It draws NUM_BARS vertical
// bars. Each bar has its own brightness level, which is loaded to MAX_LEVEL
// when the bar's strike input pulses. The level then decays by DECAY_STEP
// once per video frame. Everything runs in the pixel clock domain.
//
// Ports
//   clk_25      in   pixel clock (the only clock)
//   rst         in   asynchronous, active-high reset
//   pixel_x     in   current pixel column from the timing generator
//   pixel_y     in   current pixel row from the timing generator
//   strike      in   per-bar strike request, one-cycle pulse per hit
//   pixel_r/g/b out  registered colour for the pixel presented last cycle
//   bar_active  out  registered flag per bar, set while its level is non-zero
//
// Interface contract: there is no handshake. pixel_x/pixel_y are sampled
// every cycle, and the colour for them appears one clk_25 edge later. A strike
// pulse is always accepted in the cycle it is high.
// -----------------------------------------------------------------------------
module xylo_bar_renderer #(
  parameter int NUM_BARS   = 8,
  parameter int LEVEL_W    = 8,
  parameter int MAX_LEVEL  = 255,
  parameter int DECAY_STEP = 8,
  parameter int BAR_X0     = 40,
  parameter int BAR_W      = 60,
  parameter int BAR_GAP    = 10,
  parameter int BAR_Y0     = 160,
  parameter int BAR_H      = 160,
  parameter int BAR_BASE   = 64,
  parameter int FRAME_Y    = 480
) (
  input  logic                clk_25,
  input  logic                rst,
  input  logic [9:0]          pixel_x,
  input  logic [9:0]          pixel_y,
  input  logic [NUM_BARS-1:0] strike,
  output logic [7:0]          pixel_r,
  output logic [7:0]          pixel_g,
  output logic [7:0]          pixel_b,
  output logic [NUM_BARS-1:0] bar_active
);

  localparam int PITCH = BAR_W + BAR_GAP;
  localparam logic [LEVEL_W-1:0] MAX_L   = LEVEL_W'(MAX_LEVEL);
  localparam logic [LEVEL_W-1:0] DECAY_L = LEVEL_W'(DECAY_STEP);

  logic [LEVEL_W-1:0]  level_q [NUM_BARS];
  logic [LEVEL_W-1:0]  level_d [NUM_BARS];
  logic                cond_d_q, cond_d_d;
  logic [7:0]          pixel_r_q, pixel_r_d;
  logic [7:0]          pixel_g_q, pixel_g_d;
  logic [7:0]          pixel_b_q, pixel_b_d;
  logic [NUM_BARS-1:0] bar_active_q, bar_active_d;

  logic                cond;
  logic                tick;
  logic                hit;
  logic [LEVEL_W-1:0]  sel_level;
  logic [31:0]         red_sum;

  // Frame tick: rising edge of the (0, FRAME_Y) condition. If the
  // coordinates are held there, only one tick is generated.
  assign cond     = (pixel_x == 10'd0) && (pixel_y == 10'(FRAME_Y));
  assign tick     = cond && !cond_d_q;
  assign cond_d_d = cond;

  // Geometry decode uses one comparator set per bar. The bars never overlap,
  // so at most one of them can hit, and a plain mux is enough.
  always_comb begin
    hit       = 1'b0;
    sel_level = '0;
    for (int i = 0; i < NUM_BARS; i++) begin
      if ((int'(pixel_x) >= BAR_X0 + i * PITCH) &&
          (int'(pixel_x) <= BAR_X0 + i * PITCH + BAR_W - 1) &&
          (int'(pixel_y) >= BAR_Y0) &&
          (int'(pixel_y) <= BAR_Y0 + BAR_H - 1)) begin
        hit       = 1'b1;
        sel_level = level_q[i];
      end
    end
  end

  // The red channel is the base colour plus the level, saturated at 255.
  always_comb begin
    red_sum   = 32'(BAR_BASE) + 32'(sel_level);
    pixel_r_d = 8'd0;
    pixel_g_d = 8'd0;
    pixel_b_d = 8'd0;
    if (hit) begin
      pixel_r_d = (red_sum > 32'd255) ? 8'd255 : red_sum[7:0];
      pixel_g_d = 8'(BAR_BASE);
      pixel_b_d = 8'(BAR_BASE);
    end
  end

  // Level update. A strike wins over a same-cycle tick, and decay saturates
  // at zero.
  always_comb begin
    for (int i = 0; i < NUM_BARS; i++) begin
      level_d[i]      = level_q[i];
      bar_active_d[i] = (level_q[i] != '0);
      if (strike[i]) begin
        level_d[i] = MAX_L;
      end else if (tick) begin
        level_d[i] = (level_q[i] > DECAY_L) ? level_q[i] - DECAY_L : '0;
      end
    end
  end

  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BARS; i++) begin
        level_q[i] <= '0;
      end
      cond_d_q     <= 1'b0;
      pixel_r_q    <= 8'd0;
      pixel_g_q    <= 8'd0;
      pixel_b_q    <= 8'd0;
      bar_active_q <= '0;
    end else begin
      for (int i = 0; i < NUM_BARS; i++) begin
        level_q[i] <= level_d[i];
      end
      cond_d_q     <= cond_d_d;
      pixel_r_q    <= pixel_r_d;
      pixel_g_q    <= pixel_g_d;
      pixel_b_q    <= pixel_b_d;
      bar_active_q <= bar_active_d;
    end
  end

  assign pixel_r    = pixel_r_q;
  assign pixel_g    = pixel_g_q;
  assign pixel_b    = pixel_b_q;
  assign bar_active = bar_active_q;

endmodule

// File: tb/tb_xylo_bar_renderer.sv
// -----------------------------------------------------------------------------
// tb_xylo_bar_renderer
//
// Directed and random stimulus for xylo_bar_renderer with its default
// parameters. A behavioural model holds the eight bar levels as integers and
// derives each pixel's colour from the bar rectangles.
// -----------------------------------------------------------------------------
module tb_xylo_bar_renderer;

  logic       clk_25;
  logic       rst;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic [7:0] strike;
  logic [7:0] pixel_r;
  logic [7:0] pixel_g;
  logic [7:0] pixel_b;
  logic [7:0] bar_active;

  int total;
  int bad;

  // Behavioural model state.
  int lvl [8];
  bit prev_cond;

  xylo_bar_renderer dut (
    .clk_25     (clk_25),
    .rst        (rst),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .strike     (strike),
    .pixel_r    (pixel_r),
    .pixel_g    (pixel_g),
    .pixel_b    (pixel_b),
    .bar_active (bar_active)
  );

  // Clock and reset block.
  initial begin
    clk_25 = 1'b0;
    forever #20 clk_25 = ~clk_25;
  end

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) lvl[i] = 0;
    prev_cond = 1'b0;
  endtask

  // Colour of a pixel taken from the bar rectangles and the current levels.
  task automatic model_colour(input int x, input int y,
                              output int er, output int eg, output int eb);
    er = 0; eg = 0; eb = 0;
    for (int i = 0; i < 8; i++) begin
      if (x >= 40 + 70 * i && x <= 40 + 70 * i + 59 && y >= 160 && y <= 319) begin
        er = (64 + lvl[i] > 255) ? 255 : 64 + lvl[i];
        eg = 64;
        eb = 64;
      end
    end
  endtask

  // One pixel-clock cycle: drive the inputs, predict, clock, then compare.
  task automatic cyc(input int x, input int y, input logic [7:0] s);
    int  er, eg, eb, ea;
    bit  c, tk;
    pixel_x = 10'(x);
    pixel_y = 10'(y);
    strike  = s;
    model_colour(x, y, er, eg, eb);
    ea = 0;
    for (int i = 0; i < 8; i++) if (lvl[i] != 0) ea |= (1 << i);
    c  = (x == 0 && y == 480);
    tk = c && !prev_cond;
    prev_cond = c;
    for (int i = 0; i < 8; i++) begin
      if (s[i]) lvl[i] = 255;
      else if (tk) lvl[i] = (lvl[i] > 8) ? lvl[i] - 8 : 0;
    end
    @(posedge clk_25);
    #1;
    check("pixel_r", int'(pixel_r), er);
    check("pixel_g", int'(pixel_g), eg);
    check("pixel_b", int'(pixel_b), eb);
    check("bar_active", int'(bar_active), ea);
  endtask

  task automatic frame_tick();
    cyc(0, 480, 8'h00);
    cyc(1, 480, 8'h00);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    pixel_x = '0;
    pixel_y = '0;
    strike  = '0;
    model_reset();

    // Power-up reset.
    repeat (3) @(posedge clk_25);
    #1;
    check("por_r", int'(pixel_r), 0);
    check("por_active", int'(bar_active), 0);
    rst = 1'b0;

    // Mid-frame reset with bar 2 lit.
    cyc(180, 200, 8'h04);
    cyc(180, 200, 8'h00);
    cyc(200, 250, 8'h00);
    #5;
    rst = 1'b1;
    #1;
    check("rst_async_r", int'(pixel_r), 0);
    check("rst_async_g", int'(pixel_g), 0);
    check("rst_async_b", int'(pixel_b), 0);
    check("rst_async_active", int'(bar_active), 0);
    @(posedge clk_25);
    #1;
    check("rst_held_r", int'(pixel_r), 0);
    check("rst_held_active", int'(bar_active), 0);
    rst = 1'b0;
    model_reset();
    cyc(110, 200, 8'h00);
    check("post_rst_r", int'(pixel_r), 64);

    // Idle geometry around the bar edges.
    cyc(40, 160, 8'h00);
    cyc(99, 319, 8'h00);
    cyc(100, 200, 8'h00);
    check("gap_r", int'(pixel_r), 0);
    cyc(589, 200, 8'h00);
    check("last_bar_g", int'(pixel_g), 64);
    cyc(590, 200, 8'h00);
    cyc(39, 160, 8'h00);
    cyc(40, 320, 8'h00);
    check("below_bar_b", int'(pixel_b), 0);

    // Strike bar 3 and decay it to zero.
    cyc(250, 200, 8'h08);
    cyc(250, 200, 8'h00);
    check("strike3_r", int'(pixel_r), 255);
    frame_tick();
    cyc(250, 200, 8'h00);
    check("tick1_r", int'(pixel_r), 255);
    repeat (23) frame_tick();
    cyc(250, 200, 8'h00);
    check("tick24_r", int'(pixel_r), 127);
    repeat (8) frame_tick();
    cyc(250, 200, 8'h00);
    check("tick32_r", int'(pixel_r), 64);
    check("tick32_active3", int'(bar_active[3]), 0);

    // A strike coincident with a tick must reload, not decay.
    cyc(50, 200, 8'h01);
    repeat (3) frame_tick();
    cyc(5, 5, 8'h00);
    cyc(0, 480, 8'h01);
    cyc(1, 480, 8'h00);
    repeat (24) frame_tick();
    cyc(50, 200, 8'h00);
    check("strike_vs_tick_r", int'(pixel_r), 127);

    // Held frame coordinates produce a single decrement.
    cyc(400, 200, 8'h20);
    repeat (26) frame_tick();
    cyc(400, 200, 8'h00);
    check("held_pre_r", int'(pixel_r), 111);
    repeat (10) cyc(0, 480, 8'h00);
    cyc(400, 200, 8'h00);
    check("held_once_r", int'(pixel_r), 103);
    cyc(1, 480, 8'h00);
    cyc(0, 480, 8'h00);
    cyc(400, 200, 8'h00);
    check("held_again_r", int'(pixel_r), 95);

    // Retrigger and strike all bars at once.
    cyc(5, 5, 8'h02);
    repeat (2) frame_tick();
    cyc(5, 5, 8'hFF);
    cyc(5, 5, 8'h00);
    check("multi_active", int'(bar_active), 255);
    cyc(110, 200, 8'h00);
    check("multi_bar1_r", int'(pixel_r), 255);

    // Random pixels, frame ticks and sparse strikes.
    for (int n = 0; n < 600; n++) begin
      int x, y;
      logic [7:0] s;
      if ($urandom_range(0, 3) == 0) begin
        x = 0;
        y = 480;
      end else begin
        x = $urandom_range(0, 639);
        y = $urandom_range(100, 380);
      end
      s = ($urandom_range(0, 11) == 0) ? 8'($urandom) : 8'h00;
      cyc(x, y, s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
